dm_port_arbiter: RTL and testbench

Shares the single-port data memory (DM) between the CPU pipeline's LOAD/STORE stage and an external host port (program/data loader, debug probe). The CPU has priority; a starvation counter guarantees the host a slot within a bounded number of cycles. While the host holds the slot, the arbiter stalls the CPU through `cpu_stall`, which feeds the same PC-hold path as the load-use bubble. Sits between the MEM stage and the DM macro.

---
 rtl/dm_arb_pkg.sv | 19 +
 rtl/starve_counter.sv | 33 +++
 rtl/dm_port_arbiter.sv | 139 +++++++++++++
 tb/tb_dm_port_arbiter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_arb_pkg.sv
// Shared types for the data-memory port arbiter: FSM states, owner encoding, default widths.
// Pure declarations; no logic or timing of its own.
package dm_arb_pkg;

    localparam int AW_DEF = 8;
    localparam int DW_DEF = 8;

    typedef enum logic {
        IDLE    = 1'b0,
        EXT_ACK = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_EXT  = 2'd2
    } owner_e;

endpackage

// File: rtl/starve_counter.sv
// Saturating count of consecutive cycles a pending host request lost to the CPU.
// clr wins over inc; at_limit is combinational from the registered count.
module starve_counter
    import dm_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic at_limit
);

    // A limit of 0 still needs a 1-bit register; it simply never leaves 0.
    localparam int CW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (inc && !at_limit) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign at_limit = (r_cnt == LIMIT);

endmodule

// File: rtl/dm_port_arbiter.sv
// Shares the single-port DM between the MEM stage (priority) and a host port; host gets a slot
// within STARVE_LIMIT denied cycles, costs the CPU at most one stall cycle, and is acked one cycle after its strobe.
module dm_port_arbiter
    import dm_arb_pkg::*;
#(
    parameter int AW           = AW_DEF,
    parameter int DW           = DW_DEF,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_stall,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    input  logic          ext_req,
    input  logic          ext_we,
    input  logic [AW-1:0] ext_addr,
    input  logic [DW-1:0] ext_wdata,
    output logic          ext_ack,
    output logic [DW-1:0] ext_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    state_e        r_state;
    state_e        w_state_nxt;
    owner_e        w_own;
    logic          w_at_limit;
    logic          w_cnt_inc;
    logic          w_cnt_clr;
    logic          r_ext_rd;
    logic          r_cpu_rvalid;
    logic [DW-1:0] r_ext_rdata;

    starve_counter #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_starve (
        .clk      (clk),
        .rst      (rst),
        .inc      (w_cnt_inc),
        .clr      (w_cnt_clr),
        .at_limit (w_at_limit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // EXT_ACK ignores ext_req: the host is seeing its ack and dropping the request.
    always_comb begin
        w_state_nxt = r_state;
        w_own       = OWN_NONE;
        w_cnt_inc   = 1'b0;
        w_cnt_clr   = 1'b1;
        case (r_state)
            IDLE: begin
                if (ext_req && (!cpu_req || w_at_limit)) begin
                    w_own       = OWN_EXT;
                    w_state_nxt = EXT_ACK;
                end else if (cpu_req) begin
                    w_own = OWN_CPU;
                    if (ext_req) begin
                        w_cnt_inc = 1'b1;
                        w_cnt_clr = 1'b0;
                    end
                end
            end
            EXT_ACK: begin
                if (cpu_req) begin
                    w_own = OWN_CPU;
                end
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        cpu_stall = 1'b0;
        case (w_own)
            OWN_EXT: begin
                mem_en    = 1'b1;
                mem_we    = ext_we;
                mem_addr  = ext_addr;
                mem_wdata = ext_wdata;
                cpu_stall = cpu_req;
            end
            OWN_CPU: begin
                mem_en = 1'b1;
                mem_we = cpu_we;
            end
            default: begin
                mem_en = 1'b0;
            end
        endcase
        if (rst) begin
            mem_en    = 1'b0;
            mem_we    = 1'b0;
            cpu_stall = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ext_rd     <= 1'b0;
            r_ext_rdata  <= '0;
            r_cpu_rvalid <= 1'b0;
        end else begin
            r_cpu_rvalid <= cpu_req && !cpu_stall && !cpu_we;
            if (w_own == OWN_EXT) begin
                r_ext_rd <= !ext_we;
            end
            if (r_state == EXT_ACK && r_ext_rd) begin
                r_ext_rdata <= mem_rdata;
            end
        end
    end

    assign ext_ack    = (r_state == EXT_ACK);
    assign ext_rdata  = r_ext_rdata;
    assign cpu_rvalid = r_cpu_rvalid;
    assign cpu_rdata  = mem_rdata;

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Two arbiters (STARVE_LIMIT 4 and 0) each driven by directed then random traffic; a transaction-level
// model predicts grants and read data, and per-instance monitors check acks and read returns from queues.
module tb_dm_port_arbiter;

    typedef struct packed {
        int         cyc;
        logic       we;
        logic [7:0] d;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input int lim, input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL L%0d %s: got 0x%0h, want 0x%0h (t=%0t)", lim, nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] init_val(input int a);
        return (a == 16) ? 8'hA5 : 8'(a * 37 + 11);
    endfunction

    for (genvar gi = 0; gi < 2; gi++) begin : g_env
        localparam int LIM = (gi == 0) ? 4 : 0;

        logic       rst, cpu_req, cpu_we, cpu_stall, cpu_rvalid;
        logic       ext_req, ext_we, ext_ack, mem_en, mem_we;
        logic [7:0] cpu_addr, cpu_wdata, cpu_rdata, ext_addr, ext_wdata, ext_rdata;
        logic [7:0] mem_addr, mem_wdata;
        logic [7:0] mem_rdata = '0;
        logic [7:0] dm [256];
        logic [7:0] ref_mem [256];
        exp_t       q_cpu[$];
        exp_t       q_ext[$];
        int         cyc = 0;
        bit         fin = 0;

        logic [7:0] exp_hold = '0;
        logic [7:0] stg = '0;
        bit         stg_vld = 0;

        // Host bookkeeping: how long the pending request has been refused, and whether its ack is due now.
        int         m_denied = 0;
        bit         m_ack_due = 0;

        logic       h_vld = 0, h_we = 0, c_req = 0, c_we = 0, last_stall = 0;
        logic [7:0] h_addr = '0, h_wd = '0, c_addr = '0, c_wd = '0;

        dm_port_arbiter #(
            .AW(8), .DW(8), .STARVE_LIMIT(LIM)
        ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .cpu_req    (cpu_req),
            .cpu_we     (cpu_we),
            .cpu_addr   (cpu_addr),
            .cpu_wdata  (cpu_wdata),
            .cpu_stall  (cpu_stall),
            .cpu_rvalid (cpu_rvalid),
            .cpu_rdata  (cpu_rdata),
            .ext_req    (ext_req),
            .ext_we     (ext_we),
            .ext_addr   (ext_addr),
            .ext_wdata  (ext_wdata),
            .ext_ack    (ext_ack),
            .ext_rdata  (ext_rdata),
            .mem_en     (mem_en),
            .mem_we     (mem_we),
            .mem_addr   (mem_addr),
            .mem_wdata  (mem_wdata),
            .mem_rdata  (mem_rdata)
        );

        always @(posedge clk) begin
            cyc <= cyc + 1;
            if (mem_en) begin
                if (mem_we) dm[mem_addr] <= mem_wdata;
                else        mem_rdata <= dm[mem_addr];
            end
        end

        task automatic step(input logic rs, input logic cr, input logic cw, input logic [7:0] ca,
                            input logic [7:0] cd, input logic er, input logic ew, input logic [7:0] ea,
                            input logic [7:0] ed);
            bit   grant_ext, serve_cpu;
            exp_t e;
            @(posedge clk);
            #1;
            rst = rs; cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
            ext_req = er; ext_we = ew; ext_addr = ea; ext_wdata = ed;
            #1;
            grant_ext = 0;
            serve_cpu = 0;
            if (rs) begin
                m_ack_due = 0;
                m_denied  = 0;
                q_cpu.delete();
                q_ext.delete();
                exp_hold  = '0;
                stg_vld   = 0;
            end else if (m_ack_due) begin
                serve_cpu = cr;
                m_ack_due = 0;
            end else begin
                grant_ext = er && (!cr || m_denied >= LIM);
                serve_cpu = cr && !grant_ext;
                if (grant_ext) begin
                    m_denied  = 0;
                    m_ack_due = 1;
                end else if (er) begin
                    m_denied++;
                end else begin
                    m_denied = 0;
                end
            end
            chk(LIM, "cpu_stall", 32'(cpu_stall), 32'(!rs && cr && !serve_cpu));
            chk(LIM, "mem_en", 32'(mem_en), 32'(serve_cpu || grant_ext));
            e.cyc = cyc + 1;
            if (grant_ext) begin
                chk(LIM, "host mem_addr", 32'(mem_addr), 32'(ea));
                chk(LIM, "host mem_we", 32'(mem_we), 32'(ew));
                e.we = ew;
                e.d  = ref_mem[ea];
                if (ew) begin
                    chk(LIM, "host mem_wdata", 32'(mem_wdata), 32'(ed));
                    ref_mem[ea] = ed;
                end
                q_ext.push_back(e);
            end else if (serve_cpu) begin
                chk(LIM, "cpu mem_addr", 32'(mem_addr), 32'(ca));
                chk(LIM, "cpu mem_we", 32'(mem_we), 32'(cw));
                if (cw) begin
                    chk(LIM, "cpu mem_wdata", 32'(mem_wdata), 32'(cd));
                    ref_mem[ca] = cd;
                end else begin
                    e.we = 1'b0;
                    e.d  = ref_mem[ca];
                    q_cpu.push_back(e);
                end
            end
            last_stall = cpu_stall;
        endtask

        // Host holds its fields until acked and drops ext_req in the ack cycle; a stalled CPU holds its request.
        task automatic auto_cycle(input int p_cpu, input int p_we, input int p_new, input int p_wd);
            if (!last_stall) begin
                c_req  = (int'($urandom_range(99)) < p_cpu);
                c_we   = (int'($urandom_range(99)) < p_we);
                c_addr = 8'($urandom);
                c_wd   = 8'($urandom);
            end
            if (m_ack_due) begin
                h_vld = 0;
            end else if (h_vld) begin
                if (int'($urandom_range(99)) < p_wd) h_vld = 0;
            end else if (int'($urandom_range(99)) < p_new) begin
                h_vld  = 1;
                h_we   = 1'($urandom_range(1));
                h_addr = 8'($urandom);
                h_wd   = 8'($urandom);
            end
            step(0, c_req, c_we, c_addr, c_wd, h_vld, h_we, h_addr, h_wd);
        endtask

        initial begin : monitor
            exp_t e;
            bit   exp_v;
            forever begin
                @(negedge clk);
                if (stg_vld) begin
                    exp_hold = stg;
                    stg_vld  = 0;
                end
                chk(LIM, "ext_rdata", 32'(ext_rdata), 32'(exp_hold));
                exp_v = (q_cpu.size() > 0) && (q_cpu[0].cyc == cyc);
                chk(LIM, "cpu_rvalid", 32'(cpu_rvalid), 32'(exp_v));
                if (exp_v) begin
                    e = q_cpu.pop_front();
                    if (cpu_rvalid) chk(LIM, "cpu_rdata", 32'(cpu_rdata), 32'(e.d));
                end
                exp_v = (q_ext.size() > 0) && (q_ext[0].cyc == cyc);
                chk(LIM, "ext_ack", 32'(ext_ack), 32'(exp_v));
                if (exp_v) begin
                    e = q_ext.pop_front();
                    if (!e.we) begin
                        stg     = e.d;
                        stg_vld = 1;
                    end
                end
            end
        end

        initial begin : driver
            int nd;
            rst = 1; cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
            ext_req = 0; ext_we = 0; ext_addr = '0; ext_wdata = '0;
            for (int i = 0; i < 256; i++) begin
                dm[i]      <= init_val(i);
                ref_mem[i] = init_val(i);
            end
            repeat (3) step(1, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);

            // Host read of 0x10 with the CPU idle.
            step(0, 0, 0, 8'h00, 8'h00, 1, 0, 8'h10, 8'h00);
            step(0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
            step(0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
            chk(LIM, "host read 0x10", 32'(ext_rdata), 32'h0000_00A5);

            // Back-to-back CPU loads against a pending host write.
            h_vld = 1; h_we = 1; h_addr = 8'h40; h_wd = 8'h5C; last_stall = 0;
            repeat (8) auto_cycle(100, 0, 0, 0);
            repeat (2) auto_cycle(0, 0, 0, 0);
            chk(LIM, "host write 0x40", 32'(dm[8'h40]), 32'h0000_005C);

            // Host gives up after two refused cycles, then asks again under full CPU load.
            h_vld = 1; h_we = 1; h_addr = 8'h50; h_wd = 8'hEE;
            repeat (2) auto_cycle(100, 30, 0, 0);
            h_vld = 0;
            repeat (2) auto_cycle(100, 30, 0, 0);
            h_vld = 1; h_we = 1; h_addr = 8'h60; h_wd = 8'h77;
            repeat (8) auto_cycle(100, 0, 0, 0);
            repeat (3) auto_cycle(0, 0, 0, 0);

            // Reset lands on the ack cycle of a host read, with a CPU load waiting.
            step(0, 0, 0, 8'h00, 8'h00, 1, 0, 8'h10, 8'h00);
            step(1, 1, 0, 8'h20, 8'h00, 0, 0, 8'h00, 8'h00);
            chk(LIM, "ext_ack in reset", 32'(ext_ack), 32'h0);
            step(1, 1, 0, 8'h20, 8'h00, 0, 0, 8'h00, 8'h00);
            step(0, 1, 1, 8'h20, 8'h33, 0, 0, 8'h00, 8'h00);
            step(0, 1, 0, 8'h20, 8'h00, 0, 0, 8'h00, 8'h00);
            step(0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
            chk(LIM, "store 0x20 after reset", 32'(dm[8'h20]), 32'h0000_0033);
            last_stall = 0;

            repeat (1500) auto_cycle(60, 40, 35, 5);
            repeat (6) auto_cycle(0, 0, 0, 0);
            @(negedge clk);
            #1;
            chk(LIM, "cpu reads outstanding", 32'(q_cpu.size()), 32'h0);
            chk(LIM, "host acks outstanding", 32'(q_ext.size()), 32'h0);
            nd = 0;
            for (int i = 0; i < 256; i++) if (dm[i] !== ref_mem[i]) nd++;
            chk(LIM, "DM bytes differing", 32'(nd), 32'h0);
            fin = 1;
        end
    end

    initial begin
        for (int i = 0; i < 40000 && !(g_env[0].fin && g_env[1].fin); i++) @(posedge clk);
        if (!(g_env[0].fin && g_env[1].fin)) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout: finished %0d/%0d, want 1/1", g_env[0].fin, g_env[1].fin);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
